lcd_8080_tx: RTL and testbench

- Byte-stream to 8080-style parallel LCD write engine; sits directly downstream of the video pixel/command sequencer and drives the lcd_d / lcd_rs / lcd_wr_n / lcd_cs_n pads.
- Also synchronises the panel tearing signal lcd_fmark and returns a one-cycle frame strobe to the sequencer.
- Accepts {rs, byte} beats over a valid/ready handshake and sustains one byte per WR_LO_CYC+WR_HI_CYC cycles when streaming.

---
 rtl/lcd_8080_tx.sv | 170 +++++++++++++++++
 tb/tb_lcd_8080_tx.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_8080_tx.sv
// 8080-style parallel LCD write engine with tearing-effect (fmark) synchroniser.
// Optional SOF gating on the frame strobe is enabled by defining LCD_TX_FMARK_GATE_EN.
module lcd_8080_tx #(
    parameter int WR_LO_CYC   = 2,
    parameter int WR_HI_CYC   = 2,
    parameter int CS_IDLE_CYC = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_rs,
    input  logic       in_sof,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] lcd_d,
    output logic       lcd_rs,
    output logic       lcd_wr_n,
    output logic       lcd_cs_n,
    input  logic       lcd_fmark,
    output logic       fmark_stb,
    output logic       busy
);

    localparam int WR_MAX     = (WR_LO_CYC > WR_HI_CYC) ? WR_LO_CYC : WR_HI_CYC;
    localparam int WR_CNT_W   = $clog2(WR_MAX + 1);
    localparam int IDLE_CNT_W = $clog2(CS_IDLE_CYC + 1);

    localparam logic [WR_CNT_W-1:0]   LO_LAST   = WR_CNT_W'(WR_LO_CYC - 1);
    localparam logic [WR_CNT_W-1:0]   HI_LAST   = WR_CNT_W'(WR_HI_CYC - 1);
    localparam logic [IDLE_CNT_W-1:0] IDLE_LAST = IDLE_CNT_W'(CS_IDLE_CYC - 1);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_CS_SETUP = 3'd1;
    localparam logic [2:0] ST_WR_LO    = 3'd2;
    localparam logic [2:0] ST_WR_HI    = 3'd3;
    localparam logic [2:0] ST_GAP      = 3'd4;

    logic [2:0]            state;
    logic [WR_CNT_W-1:0]   wr_cnt;
    logic [IDLE_CNT_W-1:0] idle_cnt;
    logic                  hi_last;
    logic                  ready_slot;
    logic                  sof_block;
    logic                  accept;

    // Final WR_HI cycle is the only in-transfer slot where the next byte can be taken.
    assign hi_last    = (state == ST_WR_HI) && (wr_cnt == HI_LAST);
    assign ready_slot = ~rst & ((state == ST_IDLE) | (state == ST_GAP) | hi_last);
    assign in_ready   = ready_slot & ~sof_block;
    assign accept     = in_valid & in_ready;
    assign busy       = (state != ST_IDLE);

`ifdef LCD_TX_FMARK_GATE_EN
    logic frame_ok;

    assign sof_block = in_sof & ~frame_ok;

    // A strobe coincident with an SOF accept keeps the frame open.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_ok <= 1'b0;
        end else if (fmark_stb) begin
            frame_ok <= 1'b1;
        end else if (accept && in_sof) begin
            frame_ok <= 1'b0;
        end
    end
`else
    logic unused_sof;

    assign sof_block  = 1'b0;
    assign unused_sof = in_sof;
`endif

    // Write engine: bus outputs are all registered here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            wr_cnt   <= '0;
            idle_cnt <= '0;
            lcd_d    <= '0;
            lcd_rs   <= 1'b0;
            lcd_wr_n <= 1'b1;
            lcd_cs_n <= 1'b1;
        end else begin
            if (accept) begin
                lcd_d  <= in_data;
                lcd_rs <= in_rs;
            end
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        lcd_cs_n <= 1'b0;
                        state    <= ST_CS_SETUP;
                    end
                end
                ST_CS_SETUP: begin
                    lcd_wr_n <= 1'b0;
                    wr_cnt   <= '0;
                    state    <= ST_WR_LO;
                end
                ST_WR_LO: begin
                    if (wr_cnt == LO_LAST) begin
                        lcd_wr_n <= 1'b1;
                        wr_cnt   <= '0;
                        state    <= ST_WR_HI;
                    end else begin
                        wr_cnt <= wr_cnt + 1'b1;
                    end
                end
                ST_WR_HI: begin
                    if (wr_cnt == HI_LAST) begin
                        wr_cnt <= '0;
                        if (accept) begin
                            lcd_wr_n <= 1'b0;
                            state    <= ST_WR_LO;
                        end else begin
                            idle_cnt <= '0;
                            state    <= ST_GAP;
                        end
                    end else begin
                        wr_cnt <= wr_cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    // Chip select stays low here, so a late byte skips CS_SETUP.
                    if (accept) begin
                        lcd_wr_n <= 1'b0;
                        wr_cnt   <= '0;
                        idle_cnt <= '0;
                        state    <= ST_WR_LO;
                    end else if (idle_cnt == IDLE_LAST) begin
                        lcd_cs_n <= 1'b1;
                        idle_cnt <= '0;
                        state    <= ST_IDLE;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                default: begin
                    lcd_wr_n <= 1'b1;
                    lcd_cs_n <= 1'b1;
                    wr_cnt   <= '0;
                    idle_cnt <= '0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

    logic fmark_p0;
    logic fmark_p1;
    logic fmark_p2;

    // Two-flop synchroniser, previous-value flop, registered rising-edge strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fmark_p0  <= 1'b0;
            fmark_p1  <= 1'b0;
            fmark_p2  <= 1'b0;
            fmark_stb <= 1'b0;
        end else begin
            fmark_p0  <= lcd_fmark;
            fmark_p1  <= fmark_p0;
            fmark_p2  <= fmark_p1;
            fmark_stb <= fmark_p1 & ~fmark_p2;
        end
    end

endmodule

// File: tb/tb_lcd_8080_tx.sv
// Self-checking bench for lcd_8080_tx: directed vector table, hand sequences and
// randomized traffic against a timestamp-based reference model.
module tb_lcd_8080_tx;

    localparam int LO   = 2;
    localparam int HI   = 2;
    localparam int IDLE = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_rs = 1'b0;
    logic       in_sof = 1'b0;
    logic       in_valid = 1'b0;
    logic       lcd_fmark = 1'b0;
    logic       in_ready;
    logic [7:0] lcd_d;
    logic       lcd_rs;
    logic       lcd_wr_n;
    logic       lcd_cs_n;
    logic       fmark_stb;
    logic       busy;

    always #5 clk = ~clk;

    lcd_8080_tx #(
        .WR_LO_CYC  (LO),
        .WR_HI_CYC  (HI),
        .CS_IDLE_CYC(IDLE)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_rs    (in_rs),
        .in_sof   (in_sof),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .lcd_d    (lcd_d),
        .lcd_rs   (lcd_rs),
        .lcd_wr_n (lcd_wr_n),
        .lcd_cs_n (lcd_cs_n),
        .lcd_fmark(lcd_fmark),
        .fmark_stb(fmark_stb),
        .busy     (busy)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model: timestamps of the last accepted byte.
    int         m_r;         // first cycle wr_n is high again for the last byte
    int         m_cs_start;  // first cycle cs_n is low in the current burst
    logic [7:0] m_d;
    logic       m_rs;
    bit         fh [5];
`ifdef LCD_TX_FMARK_GATE_EN
    bit         m_fok;
`endif

    typedef struct {
        int         c;
        logic [7:0] d;
        logic       rs;
    } rise_t;
    rise_t rises[$];
    logic  prev_wr;
    int    stb_cnt;
    int    stb_last;

    typedef struct {
        bit         v;
        logic [7:0] d;
        bit         rs;
        bit         e_cs_n;
        bit         e_wr_n;
        bit         e_rdy;
        bit         e_busy;
        logic [7:0] e_d;
        bit         e_rs;
    } vec_t;
    vec_t tbl [12];

    task automatic chk1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %b, want %b", name, cyc, act, exp);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h, want %h", name, cyc, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0d, want %0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_r        = -1000;
        m_cs_start = 1;
        m_d        = '0;
        m_rs       = 1'b0;
        for (int i = 0; i < 5; i++) fh[i] = 1'b0;
`ifdef LCD_TX_FMARK_GATE_EN
        m_fok = 1'b0;
`endif
        prev_wr = 1'b1;
    endtask

    // One clock cycle: drive inputs at the falling edge, then compare every output.
    task automatic tick(input bit v, input bit rs, input logic [7:0] d, input bit sof, input bit fm);
        bit e_wr, e_cs, e_rdy, e_stb, acc;
        @(negedge clk);
        in_valid  = v;
        in_rs     = rs;
        in_data   = d;
        in_sof    = sof;
        lcd_fmark = fm;
        for (int i = 4; i > 0; i--) fh[i] = fh[i-1];
        fh[0] = fm;
        #1;
        e_wr  = !(cyc >= m_r - LO && cyc <= m_r - 1);
        e_cs  = !(cyc >= m_cs_start && cyc <= m_r + HI + IDLE - 1);
        e_rdy = (cyc >= m_r + HI - 1);
`ifdef LCD_TX_FMARK_GATE_EN
        if (sof && !m_fok) e_rdy = 1'b0;
`endif
        e_stb = fh[3] & ~fh[4];
        chk1("model in_ready", in_ready, e_rdy);
        chk1("model wr_n", lcd_wr_n, e_wr);
        chk1("model cs_n", lcd_cs_n, e_cs);
        chk1("model busy", busy, !e_cs);
        chk8("model lcd_d", lcd_d, m_d);
        chk1("model lcd_rs", lcd_rs, m_rs);
        chk1("model fmark_stb", fmark_stb, e_stb);
        if (prev_wr === 1'b0 && lcd_wr_n === 1'b1) rises.push_back('{cyc, lcd_d, lcd_rs});
        prev_wr = lcd_wr_n;
        if (fmark_stb === 1'b1) begin
            stb_cnt++;
            stb_last = cyc;
        end
        acc = v && e_rdy;
        if (acc) begin
            if (e_cs) m_cs_start = cyc + 1;
            m_r  = cyc + 1 + LO + (e_cs ? 1 : 0);
            m_d  = d;
            m_rs = rs;
        end
`ifdef LCD_TX_FMARK_GATE_EN
        if (e_stb) m_fok = 1'b1;
        else if (acc && sof) m_fok = 1'b0;
`endif
        cyc++;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk1({tag, " cs_n"}, lcd_cs_n, 1'b1);
        chk1({tag, " wr_n"}, lcd_wr_n, 1'b1);
        chk1({tag, " busy"}, busy, 1'b0);
        chk1({tag, " in_ready"}, in_ready, 1'b0);
        chk8({tag, " lcd_d"}, lcd_d, 8'h00);
        chk1({tag, " lcd_rs"}, lcd_rs, 1'b0);
        chk1({tag, " fmark_stb"}, fmark_stb, 1'b0);
    endtask

    // Asynchronous reset asserted between clock edges and checked before the next edge.
    task automatic mid_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_outputs("async rst");
        in_valid  = 1'b0;
        lcd_fmark = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        int k, c0, acc_c, pct, fm_left;
        bit fm_lvl;

        tbl[0]  = '{1'b1, 8'h2C, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
        tbl[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h2C, 1'b0};
        tbl[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h2C, 1'b0};
        tbl[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h2C, 1'b0};
        tbl[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h2C, 1'b0};
        tbl[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h2C, 1'b0};
        tbl[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h2C, 1'b0};
        tbl[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h2C, 1'b0};
        tbl[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h2C, 1'b0};
        tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h2C, 1'b0};
        tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h2C, 1'b0};
        tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h2C, 1'b0};
        stb_cnt  = 0;
        stb_last = -1;

        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Single command byte 0x2C from IDLE, cycle-by-cycle against the table.
        for (int i = 0; i < 12; i++) begin
            tick(tbl[i].v, tbl[i].rs, tbl[i].d, 1'b0, 1'b0);
            chk1($sformatf("vec%0d cs_n", i), lcd_cs_n, tbl[i].e_cs_n);
            chk1($sformatf("vec%0d wr_n", i), lcd_wr_n, tbl[i].e_wr_n);
            chk1($sformatf("vec%0d in_ready", i), in_ready, tbl[i].e_rdy);
            chk1($sformatf("vec%0d busy", i), busy, tbl[i].e_busy);
            chk8($sformatf("vec%0d lcd_d", i), lcd_d, tbl[i].e_d);
            chk1($sformatf("vec%0d lcd_rs", i), lcd_rs, tbl[i].e_rs);
        end

        // Streamed data bytes with in_valid held.
        rises.delete();
        k = 0;
        for (int i = 0; i < 40; i++) begin
            tick(k < 4, 1'b1, 8'(k + 1), 1'b0, 1'b0);
            if (k < 4 && in_ready === 1'b1) k++;
        end
        chki("stream rise count", rises.size(), 4);
        for (int i = 0; i < rises.size() && i < 4; i++) begin
            chk8($sformatf("stream byte%0d", i), rises[i].d, 8'(i + 1));
            chk1($sformatf("stream rs%0d", i), rises[i].rs, 1'b1);
            if (i > 0) chki($sformatf("stream period%0d", i), rises[i].c - rises[i-1].c, LO + HI);
        end

        // Second byte arriving two cycles into GAP.
        for (int o = 0; o <= 17; o++) begin
            tick(o == 0 || o == 8, 1'b0, (o == 8) ? 8'h88 : 8'h77, 1'b0, 1'b0);
            if (o == 8) chk1("gap in_ready", in_ready, 1'b1);
            if (o == 9) chk1("gap straight to wr_lo", lcd_wr_n, 1'b0);
            if (o >= 1 && o <= 16) chk1("gap cs_n held", lcd_cs_n, 1'b0);
            if (o == 17) chk1("gap cs_n release", lcd_cs_n, 1'b1);
        end

        // Long fmark pulses: one strobe each, three edges after the rise.
        for (int p = 0; p < 2; p++) begin
            stb_cnt = 0;
            c0 = cyc;
            for (int i = 0; i < 300; i++) tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
            for (int i = 0; i < 40; i++) tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
            chki($sformatf("fmark pulse%0d count", p), stb_cnt, 1);
            chki($sformatf("fmark pulse%0d latency", p), stb_last, c0 + 3);
        end

        // Randomized traffic with bursty valid and random fmark pulses.
        fm_lvl  = 1'b0;
        fm_left = 5;
        for (int blk = 0; blk < 24; blk++) begin
            case (blk % 3)
                0:       pct = 95;
                1:       pct = 40;
                default: pct = 8;
            endcase
            for (int i = 0; i < 100; i++) begin
                if (fm_left == 0) begin
                    fm_lvl  = !fm_lvl;
                    fm_left = fm_lvl ? int'($urandom_range(1, 6)) : int'($urandom_range(2, 40));
                end
                fm_left--;
                tick(int'($urandom_range(0, 99)) < pct, 1'($urandom_range(0, 1)), 8'($urandom),
                     $urandom_range(0, 7) == 0, fm_lvl);
            end
        end
        for (int i = 0; i < 12; i++) tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

        // Reset during WR_LO drops the byte; a fresh byte then completes.
        rises.delete();
        tick(1'b1, 1'b1, 8'hA1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        chk1("pre-reset wr_lo", lcd_wr_n, 1'b0);
        mid_reset();
        tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 8'h5A, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        chki("post-reset rise count", rises.size(), 1);
        if (rises.size() > 0) begin
            chk8("post-reset byte", rises[0].d, 8'h5A);
            chk1("post-reset rs", rises[0].rs, 1'b0);
        end

`ifdef LCD_TX_FMARK_GATE_EN
        // SOF beats wait for a frame strobe; each accept consumes it.
        mid_reset();
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 12; i++) begin
                tick(1'b1, 1'b1, 8'(8'h2C + p), 1'b1, 1'b0);
                chk1($sformatf("sof%0d blocked", p), in_ready, 1'b0);
            end
            c0    = cyc;
            acc_c = -1;
            for (int i = 0; i < 20 && acc_c < 0; i++) begin
                tick(1'b1, 1'b1, 8'(8'h2C + p), 1'b1, (cyc - c0) < 5);
                if (in_ready === 1'b1) acc_c = cyc - 1;
            end
            chki($sformatf("sof%0d accept cycle", p), acc_c, c0 + 4);
        end
        for (int i = 0; i < 12; i++) tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
`else
        // Without the gate, an SOF beat is taken immediately even with no fmark seen.
        mid_reset();
        tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 8'h2C, 1'b1, 1'b0);
        chk1("sof ignored in_ready", in_ready, 1'b1);
        for (int i = 0; i < 12; i++) tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
